// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: SIMT reconvergence stack entry and defaults
package cpu_types_pkg;

    localparam int SIMT_THREADS = 4;
    localparam int SIMT_DEPTH   = 8;
    localparam int SIMT_PC_W    = 32;

    typedef struct packed {
        logic [SIMT_PC_W-1:0]    rpc;
        logic [SIMT_PC_W-1:0]    npc;
        logic [SIMT_THREADS-1:0] emask;
    } simt_entry_t;

endpackage

// File: rtl/simt_stack_mem.sv
// rtl/simt_stack_mem.sv - divergence stack storage, two write ports and one async read
module simt_stack_mem
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = SIMT_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW-1:0] waddr0,
    input  simt_entry_t wdata0,
    input  logic [AW-1:0] waddr1,
    input  simt_entry_t wdata1,
    input  logic [AW-1:0] raddr,
    output simt_entry_t rdata
);

    simt_entry_t mem [DEPTH];

    // Both entries of a divergence land together; the addresses are always distinct.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr0] <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simt_reconv_stack.sv
// rtl/simt_reconv_stack.sv - per-warp SIMT divergence/reconvergence stack with PC redirect
module simt_reconv_stack
    import cpu_types_pkg::*;
#(
    parameter int THREADS = SIMT_THREADS,
    parameter int DEPTH   = SIMT_DEPTH,
    parameter int PC_W    = SIMT_PC_W
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       en,
    input  logic [PC_W-1:0]            pc,
    input  logic [PC_W-1:0]            br_target,
    input  logic                       pushEn,
    input  logic                       vbrEn [THREADS],
    input  logic                       sync_wen,
    input  logic [PC_W-1:0]            sync_addr,
    output logic                       mask [THREADS],
    output logic                       redirect,
    output logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [THREADS-1:0] mask_q;
    logic [PC_W-1:0]    act_rpc;
    logic [PC_W-1:0]    sync_q;
    logic [PW-1:0]      ptr;
    logic               overflow_q;

    logic [THREADS-1:0] t_vec;
    logic [THREADS-1:0] n_vec;
    logic               divergent;
    logic               pop;
    logic               push_go;
    simt_entry_t        top_entry;
    simt_entry_t        rc_entry;
    simt_entry_t        nt_entry;

    always_comb begin
        t_vec = '0;
        for (int i = 0; i < THREADS; i++) begin
            t_vec[i] = vbrEn[i];
            mask[i]  = mask_q[i];
        end
    end

    assign n_vec     = mask_q & ~t_vec;
    assign empty     = (ptr == '0);
    assign full      = (ptr > PW'(DEPTH-2));
    assign depth     = ptr;
    assign overflow  = overflow_q;
    assign divergent = pushEn & en & (t_vec != '0) & (n_vec != '0);
    assign pop       = en & ~empty & (pc == act_rpc);
    assign push_go   = divergent & ~pop & ~full;

    assign rc_entry = '{rpc: act_rpc, npc: sync_q,             emask: mask_q};
    assign nt_entry = '{rpc: sync_q,  npc: pc + PC_W'(4),      emask: n_vec};

    simt_stack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk    (CLK),
        .we     (push_go),
        .waddr0 (ptr[AW-1:0]),
        .wdata0 (rc_entry),
        .waddr1 (ptr[AW-1:0] + AW'(1)),
        .wdata1 (nt_entry),
        .raddr  (ptr[AW-1:0] - AW'(1)),
        .rdata  (top_entry)
    );

    // Pop squashes the instruction at the reconvergence PC so it re-issues under the restored mask.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (pop) begin
            redirect    = 1'b1;
            redirect_pc = top_entry.npc;
        end else if (push_go) begin
            redirect    = 1'b1;
            redirect_pc = br_target;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mask_q     <= '1;
            act_rpc    <= '1;
            sync_q     <= '0;
            ptr        <= '0;
            overflow_q <= 1'b0;
        end else if (en) begin
            if (pop) begin
                mask_q  <= top_entry.emask;
                act_rpc <= top_entry.rpc;
                ptr     <= ptr - PW'(1);
            end else if (divergent) begin
                if (!full) begin
                    mask_q  <= t_vec;
                    act_rpc <= sync_q;
                    ptr     <= ptr + PW'(2);
                end else begin
                    overflow_q <= 1'b1;
                end
            end
            // The divergence above has already consumed the old sync_q.
            if (sync_wen) begin
                sync_q <= sync_addr;
            end
        end
    end

endmodule

// File: tb/tb_simt_reconv_stack.sv
// tb/tb_simt_reconv_stack.sv - self-checking bench for simt_reconv_stack (DEPTH=4)
module tb_simt_reconv_stack;

    localparam int TH = 4;
    localparam int DP = 4;
    localparam int PW = 32;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] pc = '0;
    logic [PW-1:0] br_target = '0;
    logic          pushEn = 1'b0;
    logic [TH-1:0] vbr_p = '0;
    logic          vbr [TH];
    logic          sync_wen = 1'b0;
    logic [PW-1:0] sync_addr = '0;
    logic          mask [TH];
    logic [TH-1:0] mask_p;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic [2:0]    depth;
    logic          empty, full, overflow;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic [PW-1:0] rpc;
        logic [PW-1:0] npc;
        logic [TH-1:0] m;
    } ment_t;

    ment_t         q[$];
    logic [TH-1:0] m_mask = '1;
    logic [PW-1:0] m_rpc = '1;
    logic [PW-1:0] m_sync = '0;
    logic          m_ovf = 1'b0;

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < TH; i++) begin
            vbr[i]    = vbr_p[i];
            mask_p[i] = mask[i];
        end
    end

    simt_reconv_stack #(.THREADS(TH), .DEPTH(DP), .PC_W(PW)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .pc(pc), .br_target(br_target),
        .pushEn(pushEn), .vbrEn(vbr), .sync_wen(sync_wen), .sync_addr(sync_addr),
        .mask(mask), .redirect(redirect), .redirect_pc(redirect_pc),
        .depth(depth), .empty(empty), .full(full), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a queue of entries; a divergence appends two, a pop removes one.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q.delete();
            m_mask = '1;
            m_rpc  = '1;
            m_sync = '0;
            m_ovf  = 1'b0;
        end else if (en) begin
            logic [TH-1:0] t, n;
            ment_t e;
            t = vbr_p;
            n = m_mask & ~t;
            if (q.size() != 0 && pc == m_rpc) begin
                e = q.pop_back();
                m_mask = e.m;
                m_rpc  = e.rpc;
            end else if (pushEn && t != 0 && n != 0) begin
                if (q.size() > DP - 2) begin
                    m_ovf = 1'b1;
                end else begin
                    q.push_back('{rpc: m_rpc, npc: m_sync, m: m_mask});
                    q.push_back('{rpc: m_sync, npc: pc + 32'd4, m: n});
                    m_rpc  = m_sync;
                    m_mask = t;
                end
            end
            if (sync_wen) m_sync = sync_addr;
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            logic [TH-1:0] t, n;
            logic          er;
            logic [PW-1:0] epc;
            t = vbr_p;
            n = m_mask & ~t;
            er = 1'b0;
            epc = '0;
            if (en && q.size() != 0 && pc == m_rpc) begin
                er = 1'b1;
                epc = q[q.size()-1].npc;
            end else if (en && pushEn && t != 0 && n != 0 && q.size() <= DP - 2) begin
                er = 1'b1;
                epc = br_target;
            end
            chk("m_redirect", 32'(redirect), 32'(er));
            chk("m_redirect_pc", redirect_pc, epc);
            chk("m_mask", 32'(mask_p), 32'(m_mask));
            chk("m_depth", 32'(depth), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full", 32'(full), 32'(q.size() > DP - 2));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic drive(input logic e, input logic [31:0] p, input logic pe, input logic [3:0] v,
                         input logic [31:0] tg, input logic sw, input logic [31:0] sa);
        en = e; pc = p; pushEn = pe; vbr_p = v; br_target = tg; sync_wen = sw; sync_addr = sa;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #1;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_mask", 32'(mask_p), 32'hF);
        chk("rst_empty", 32'(empty), 32'd1);
        nRST = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reset_mask", 32'(mask_p), 32'hF);
        chk("reset_depth", 32'(depth), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_redirect", 32'(redirect), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        nRST = 1'b1;
        tick();

        drive(1, 32'h40, 1, 4'hF, 32'h80, 0, 0);
        chk("uniform_redirect", 32'(redirect), 32'd0);
        tick();
        chk("uniform_depth", 32'(depth), 32'd0);
        chk("uniform_mask", 32'(mask_p), 32'hF);

        drive(1, 32'h3C, 0, 0, 0, 1, 32'hC0);
        tick();
        drive(1, 32'h40, 1, 4'h5, 32'h80, 0, 0);
        chk("div_redirect", 32'(redirect), 32'd1);
        chk("div_redirect_pc", redirect_pc, 32'h80);
        tick();
        chk("div_mask", 32'(mask_p), 32'h5);
        chk("div_depth", 32'(depth), 32'd2);

        drive(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("pop1_redirect_pc", redirect_pc, 32'h44);
        tick();
        chk("pop1_mask", 32'(mask_p), 32'hA);
        chk("pop1_depth", 32'(depth), 32'd1);
        drive(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("pop2_redirect_pc", redirect_pc, 32'hC0);
        tick();
        chk("pop2_mask", 32'(mask_p), 32'hF);
        chk("pop2_depth", 32'(depth), 32'd0);
        drive(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("rpc_cleared_redirect", 32'(redirect), 32'd0);
        tick();

        drive(1, 32'h40, 1, 4'h5, 32'h80, 0, 0);
        tick();
        drive(0, 32'hC0, 0, 0, 0, 0, 0);
        chk("en0_redirect", 32'(redirect), 32'd0);
        tick();
        chk("en0_depth", 32'(depth), 32'd2);

        drive(0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        tick();

        drive(1, 32'h3C, 0, 0, 0, 1, 32'hC0);
        tick();
        drive(1, 32'h40, 1, 4'h5, 32'h80, 0, 0);
        tick();
        drive(1, 32'hC0, 1, 4'h1, 32'h90, 0, 0);
        chk("popdiv_redirect_pc", redirect_pc, 32'h44);
        tick();
        chk("popdiv_depth", 32'(depth), 32'd1);
        chk("popdiv_mask", 32'(mask_p), 32'hA);

        drive(0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        tick();

        drive(1, 32'h0C, 0, 0, 0, 1, 32'h100);
        tick();
        drive(1, 32'h10, 1, 4'h7, 32'h20, 1, 32'h200);
        tick();
        drive(1, 32'h24, 1, 4'h3, 32'h30, 0, 0);
        chk("nest2_redirect_pc", redirect_pc, 32'h30);
        tick();
        chk("nest2_depth", 32'(depth), 32'd4);
        chk("nest2_full", 32'(full), 32'd1);
        chk("nest2_mask", 32'(mask_p), 32'h3);
        drive(1, 32'h34, 1, 4'h1, 32'h50, 0, 0);
        chk("ovf_redirect", 32'(redirect), 32'd0);
        tick();
        chk("ovf_mask", 32'(mask_p), 32'h3);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drive(1, 32'h38, 0, 0, 0, 0, 0);
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        chk("unwind1_redirect_pc", redirect_pc, 32'h28);
        tick();
        chk("unwind1_mask", 32'(mask_p), 32'h4);
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        chk("unwind2_redirect_pc", redirect_pc, 32'h200);
        tick();
        chk("unwind2_mask", 32'(mask_p), 32'h7);
        chk("unwind2_depth", 32'(depth), 32'd2);
        chk("unwind_ovf_sticky", 32'(overflow), 32'd1);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/simt_reconv_stack.md
Name: simt_reconv_stack

Overview:
- Per-warp SIMT divergence/reconvergence stack. It consumes the control unit's vector-branch outputs (pushEn, vbrEn[], branch target) and SYNC writes.
- It produces the active thread mask[] that the control unit uses to gate vregWEN/vbrEn, plus a PC redirect for the fetch stage.
- It sits between the control unit and the PC block, and closes the mask feedback loop.

Parameters:
- THREADS, 4, lanes per warp; width of every mask.
- DEPTH, 8, stack entries; must be even, >=2.
- PC_W, 32, PC/address width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  current instruction is valid and retiring this cycle. All state updates are qualified by en.
- pc  in  PC_W  PC of the current instruction.
- br_target  in  PC_W  taken target of the current VBEQ/VBNE.
- pushEn  in  1  current instruction is VBEQ/VBNE.
- vbrEn  in  1 x THREADS (unpacked)  per-lane taken flag, already ANDed with mask.
- sync_wen  in  1  current instruction is SYNC (writeSync).
- sync_addr  in  PC_W  reconvergence address carried by SYNC.
- mask  out  1 x THREADS (unpacked)  active lane mask.
- redirect  out  1  fetch must take redirect_pc instead of the normal next PC.
- redirect_pc  out  PC_W  redirect destination.
- depth  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  depth==0.
- full  out  1  depth>DEPTH-2 (a divergence cannot be accepted).
- overflow  out  1  sticky error: a divergence was dropped.

Behaviour:
- Entry (simt_entry_t) = {rpc[PC_W], npc[PC_W], emask[THREADS]}.
- Registers: mask_q, act_rpc (active reconvergence PC), sync_q, ptr, overflow_q.
- Reset (async, nRST=0):
  - mask all 1s, act_rpc all 1s (no reconvergence), sync_q 0, ptr 0, overflow 0.
  - redirect 0, redirect_pc 0, empty 1, full 0. Entry contents don't care.
- Derived per cycle:
  - T = vbrEn.
  - N = mask_q & ~T.
  - divergent = pushEn & en & (T != 0) & (N != 0).
  - pop = en & !empty & (pc == act_rpc).
- Uniform branch (T==mask_q or T==0): no stack or mask change. The PC is handled by the control unit (pc_sel 11 / fallthrough).
- sync_wen & en: sync_q <= sync_addr at the edge. Has no other effect.
- Divergence (divergent & !pop & !full): two entries are written in one cycle.
  - stack[ptr] <= {act_rpc, sync_q, mask_q} (reconvergence entry).
  - stack[ptr+1] <= {sync_q, pc+4, N} (not-taken entry).
  - ptr += 2; mask_q <= T; act_rpc <= sync_q.
  - redirect = 1, redirect_pc = br_target, combinationally in the same cycle.
- Pop (pop):
  - redirect = 1, redirect_pc = stack[ptr-1].npc, combinationally.
  - At the edge: mask_q <= emask, act_rpc <= rpc, ptr -= 1.
  - The instruction at pc is squashed and re-fetched under the new mask. Pop has priority over divergence in the same cycle; that divergence is ignored.
- Divergence while full: no push and no mask change; redirect = 0; overflow_q <= 1.
  - overflow stays set until reset.
- sync_wen in the same cycle as divergence: the divergence uses the old sync_q. The new value is latched after it.
- en=0: no state change; redirect = 0.
- pc+4 wraps modulo 2^PC_W.
- ptr never exceeds DEPTH and never underflows (pop requires !empty).
- Outputs mask, depth, empty, full and overflow come straight from registers. redirect and redirect_pc are combinational.
- Reset asserted mid-divergence discards all entries and restores the all-ones mask.

Decomposition:
- cpu_types_pkg gains:
  - simt_entry_t (packed struct, parameterised by THREADS via a package localparam).
  - SIMT_DEPTH default constant.
- One sub-module, simt_stack_mem:
  - DEPTH x entry register array, async-reset-free.
  - Dual write port (ptr, ptr+1), single combinational read at ptr-1.
- The top holds the pointer, active registers, and redirect logic.

Test Plan:
- Reset -> mask=1111, depth=0, empty=1, full=0, overflow=0, redirect=0.
- mask=1111, pushEn=1, vbrEn=1111, pc=0x40 -> redirect=0, depth stays 0, mask stays 1111.
- SYNC sync_addr=0xC0; then pc=0x40, pushEn, vbrEn=0101, br_target=0x80 -> same-cycle redirect=1, redirect_pc=0x80; next cycle mask=0101, depth=2.
- Continuing from the previous case:
  - pc=0xC0 -> redirect_pc=0x44; next cycle mask=1010, depth=1.
  - pc=0xC0 again -> redirect_pc=0xC0; next cycle mask=1111, depth=0, act_rpc=all 1s.
- DEPTH=4, nested divergences:
  - Second divergence -> depth=4, full=1.
  - Third divergence (vbrEn=0001) -> redirect=0, mask unchanged, overflow=1, and overflow stays 1.
- Other directed cases:
  - pc==act_rpc with en=0 -> no pop, no redirect.
  - Divergence and pop in the same cycle -> pop wins, depth-1.
  - nRST pulsed at depth=2 -> immediate depth=0, mask=1111.
